aig_stream_eval: RTL and testbench
==================================

Name: aig_stream_eval

Overview:
- Sequential evaluator for And-Inverter Graphs streamed as AND-node literal pairs, one node per beat, over a valid/ready handshake.
- It is the consuming end of our AIG netlist dump. Each dumped "assign nK = litA & litB" line becomes one beat.
- Used to evaluate candidate Skolem/checker AIGs in hardware against a primary-input vector without re-synthesising per formula.

Parameters:
NUM_PI, 16, number of primary inputs (vars 1..NUM_PI)
MAX_VARS, 128, variable storage depth including const var 0
LIT_W, 8, literal width; literal = 2*var + complement bit; must satisfy 2^LIT_W >= 2*MAX_VARS

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse; accepted only in IDLE
pi_vec  in  NUM_PI  primary inputs; bit i drives var i+1; sampled on accepted start
gate_valid  in  1  AND-node beat valid
gate_ready  out  1  evaluator can accept a beat
gate_lit0  in  LIT_W  first fanin literal
gate_lit1  in  LIT_W  second fanin literal
gate_last  in  1  marks final AND node of the stream
out_lit  in  LIT_W  output literal; sampled on the gate_last handshake
busy  out  1  high in any state other than IDLE
res_valid  out  1  one-cycle pulse; res_value is valid
res_value  out  1  evaluated output
err  out  1  sticky error flag; cleared by the next accepted start or by rst

Behaviour:
- Reset values: state=IDLE, gate_ready=0, busy=0, res_valid=0, res_value=0, err=0, next_var=0. Value store contents after reset are don't-care.
- Literal evaluation: val(l) = store[l>>1] XOR l[0]. store[0] is always 0, so literal 0 = false and literal 1 = true.
- IDLE:
  - gate_ready=0.
  - start=1 loads store[0]=0, store[i+1]=pi_vec[i], next_var=NUM_PI+1, clears err, then goes to STREAM.
  - start is ignored in all other states.
- STREAM:
  - gate_ready=1.
  - On handshake (gate_valid & gate_ready): store[next_var] <= val(gate_lit0) & val(gate_lit1), and next_var increments.
  - Both fanins must reference var < next_var. Referencing next_var itself or higher is a forward reference and sets err.
  - A handshake when next_var==MAX_VARS is an overflow: sets err and writes nothing.
  - On any error: go to DONE with res_value=0 and res_valid pulsed. Remaining beats are not accepted.
  - If gate_last is set on a handshake: latch out_lit and go to EVAL. The node on that beat is written as normal.
- EVAL (one cycle):
  - gate_ready=0.
  - res_value <= val(out_lit_latched), so out_lit may reference the node written on the last beat.
  - If out_lit references var >= next_var: err=1, res_value=0.
  - Go to DONE.
- DONE (one cycle): res_valid=1, then go to IDLE.
- Latency: the gate_last handshake in cycle T gives res_valid high in cycle T+2.
- Throughput: one AND node per cycle, with no bubbles while gate_valid is held high.
- Backpressure: gate_valid may stall arbitrarily. gate_lit0/gate_lit1/gate_last/out_lit must be held stable while gate_valid=1 and gate_ready=0.
- rst mid-stream: returns to IDLE next cycle with all outputs at reset values. A partially streamed AIG is discarded with no res_valid.
- An AIG with zero AND nodes is streamed as one dummy beat (lit0=1, lit1=1) with gate_last=1.
- err stays high after DONE until the next accepted start.

Test Plan:
- Basic AND, NUM_PI=2, pi_vec=2'b11, one beat (lit0=2, lit1=4, last, out_lit=6) -> res_valid at T+2, res_value=1, err=0. Repeat with pi_vec=2'b01 -> res_value=0. Repeat with out_lit=7 -> res_value=1.
- 16-input team checker AIG (37 AND nodes, vars 17..53, output literal = positive literal of the final node):
  - pi_vec=0 -> res_value=0.
  - Also compare 200 random pi_vec values against a software AIG evaluator; all must match, with no err.
- Backpressure: gate_valid toggling randomly (50%) during a 10-node stream -> same res_value as the unstalled run. next_var advances only on handshakes.
- Forward reference: NUM_PI=2, first beat lit0=8 (var 4, next_var=3) -> err=1, res_valid pulse with res_value=0. A following start clears err.
- Overflow: MAX_VARS=8, NUM_PI=2, stream 6 beats -> err on the 6th beat (next_var==8).
- Reset mid-stream after 3 beats -> no res_valid; gate_ready=0 next cycle. A fresh run then gives the correct result.

Source files
------------

// File: rtl/aig_stream_eval.sv
// -----------------------------------------------------------------------------
// aig_stream_eval
//
// Evaluates an And-Inverter Graph that arrives as a stream of AND nodes, one
// node per valid/ready beat, against a primary-input vector latched on start.
// A literal is 2*var + complement; var 0 is the constant-false variable and
// vars 1..NUM_PI are the primary inputs. Each accepted beat writes a new var
// (numbered from NUM_PI+1 upward). The beat flagged gate_last also carries
// the output literal, which is evaluated one cycle later.
//
// Ports
//   clk         clock, all state on rising edge
//   rst         synchronous active-high reset
//   start       single-cycle pulse, accepted only in IDLE
//   pi_vec      primary inputs, bit i drives var i+1, sampled on accepted start
//   gate_valid  AND-node beat valid
//   gate_ready  evaluator can accept a beat (high only while streaming)
//   gate_lit0   first fanin literal
//   gate_lit1   second fanin literal
//   gate_last   marks the final AND node of the stream
//   out_lit     output literal, sampled on the gate_last handshake
//   busy        high in any state other than IDLE
//   res_valid   one-cycle pulse, res_value is valid
//   res_value   evaluated output (0 whenever err is raised)
//   err         sticky error, cleared by the next accepted start or rst
// -----------------------------------------------------------------------------
module aig_stream_eval #(
   parameter int NUM_PI   = 16,
   parameter int MAX_VARS = 128,
   parameter int LIT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NUM_PI-1:0] pi_vec,
   input  logic              gate_valid,
   output logic              gate_ready,
   input  logic [LIT_W-1:0]  gate_lit0,
   input  logic [LIT_W-1:0]  gate_lit1,
   input  logic              gate_last,
   input  logic [LIT_W-1:0]  out_lit,
   output logic              busy,
   output logic              res_valid,
   output logic              res_value,
   output logic              err
);

   localparam int VAR_W = LIT_W - 1;
   localparam int AW    = (MAX_VARS > 1) ? $clog2(MAX_VARS) : 1;
   // next_var must be able to hold MAX_VARS itself to detect overflow.
   localparam int NV_W  = $clog2(MAX_VARS + 1);
   // Common width for var comparisons; wide enough for both a literal's var
   // field and the value MAX_VARS.
   localparam int CMP_W = (VAR_W > NV_W) ? VAR_W : NV_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      EVAL   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Value store. Entry 0 is never written or read: var 0 is the constant
   // and is forced to 0 at the read port instead.
   logic store [MAX_VARS];

   logic [NV_W-1:0]  next_var;
   logic [LIT_W-1:0] out_lit_p0;

   logic hs;
   logic ovf;
   logic fwd;
   logic beat_err;
   logic node_val;
   logic out_fwd;
   logic out_val;

   // Variable index carried by a literal, widened for comparisons.
   function automatic logic [CMP_W-1:0] lit_var(input logic [LIT_W-1:0] lit);
      return CMP_W'(lit[LIT_W-1:1]);
   endfunction

   // val(l) = store[l>>1] ^ l[0]. Vars outside the store read as 0; such
   // literals are always flagged as forward references, so the value is
   // never used for a result.
   function automatic logic lit_val(input logic [LIT_W-1:0] lit);
      logic [CMP_W-1:0] v;
      logic             s;
      v = lit_var(lit);
      if ((v == '0) || (v >= CMP_W'(MAX_VARS))) begin
         s = 1'b0;
      end else begin
         s = store[AW'(v)];
      end
      return s ^ lit[0];
   endfunction

   // Beat qualification and fanin evaluation
   always_comb begin
      hs       = gate_valid && (state == STREAM);
      ovf      = (CMP_W'(next_var) == CMP_W'(MAX_VARS));
      fwd      = (lit_var(gate_lit0) >= CMP_W'(next_var)) ||
                 (lit_var(gate_lit1) >= CMP_W'(next_var));
      beat_err = ovf || fwd;
      node_val = lit_val(gate_lit0) & lit_val(gate_lit1);
      // Output literal may name the node written on the last beat, which
      // is already below next_var by the time EVAL runs.
      out_fwd  = (lit_var(out_lit_p0) >= CMP_W'(next_var));
      out_val  = lit_val(out_lit_p0);
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            // An erroring beat wins over gate_last: no EVAL after an error.
            if (hs) begin
               if (beat_err) begin
                  state_nxt = DONE;
               end else if (gate_last) begin
                  state_nxt = EVAL;
               end
            end
         end
         EVAL:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      gate_ready = 1'b0;
      busy       = 1'b1;
      res_valid  = 1'b0;
      case (state)
         IDLE:    busy       = 1'b0;
         STREAM:  gate_ready = 1'b1;
         EVAL:    ;
         DONE:    res_valid  = 1'b1;
         default: busy       = 1'b0;
      endcase
   end

   // Control registers: allocation pointer, error and result
   always_ff @(posedge clk) begin
      if (rst) begin
         next_var  <= '0;
         err       <= 1'b0;
         res_value <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  next_var  <= NV_W'(NUM_PI + 1);
                  err       <= 1'b0;
                  res_value <= 1'b0;
               end
            end
            STREAM: begin
               if (hs) begin
                  if (beat_err) begin
                     err       <= 1'b1;
                     res_value <= 1'b0;
                  end else begin
                     next_var <= next_var + 1'b1;
                  end
               end
            end
            EVAL: begin
               if (out_fwd) begin
                  err       <= 1'b1;
                  res_value <= 1'b0;
               end else begin
                  res_value <= out_val;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath: value store and latched output literal (no reset needed)
   always_ff @(posedge clk) begin
      if ((state == IDLE) && start) begin
         for (int i = 0; i < NUM_PI; i++) begin
            store[i + 1] <= pi_vec[i];
         end
      end else if (hs && !beat_err) begin
         store[AW'(next_var)] <= node_val;
      end
   end

   always_ff @(posedge clk) begin
      if (hs && gate_last) begin
         out_lit_p0 <= out_lit;
      end
   end

endmodule

// File: tb/tb_aig_stream_eval.sv
module tb_aig_stream_eval;

   typedef struct packed {
      logic val;
      logic err;
      int   lat;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [15:0] pi_vec;
   logic        gate_valid, gate_last;
   logic [7:0]  gate_lit0, gate_lit1, out_lit;
   logic        rdy_a, busy_a, rv_a, rval_a, err_a;
   logic        rdy_b, busy_b, rv_b, rval_b, err_b;
   logic        sel;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_cyc = -1000;

   res_t act_q[$];
   res_t exp_q[$];
   res_t mon_r;

   logic [7:0] lit0_t [37];
   logic [7:0] lit1_t [37];

   // Large instance: 16 PIs, 128 vars. Small instance: 2 PIs, 8 vars.
   aig_stream_eval #(.NUM_PI(16), .MAX_VARS(128), .LIT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start_a), .pi_vec(pi_vec),
      .gate_valid(gate_valid), .gate_ready(rdy_a),
      .gate_lit0(gate_lit0), .gate_lit1(gate_lit1), .gate_last(gate_last),
      .out_lit(out_lit), .busy(busy_a), .res_valid(rv_a),
      .res_value(rval_a), .err(err_a)
   );

   aig_stream_eval #(.NUM_PI(2), .MAX_VARS(8), .LIT_W(8)) dut_s (
      .clk(clk), .rst(rst), .start(start_b), .pi_vec(pi_vec[1:0]),
      .gate_valid(gate_valid), .gate_ready(rdy_b),
      .gate_lit0(gate_lit0), .gate_lit1(gate_lit1), .gate_last(gate_last),
      .out_lit(out_lit), .busy(busy_b), .res_valid(rv_b),
      .res_value(rval_b), .err(err_b)
   );

   wire rdy  = sel ? rdy_b  : rdy_a;
   wire busy = sel ? busy_b : busy_a;
   wire rv   = sel ? rv_b   : rv_a;
   wire rval = sel ? rval_b : rval_a;
   wire errs = sel ? err_b  : err_a;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: records every result pulse with its latency from the most
   // recent accepted beat.
   always @(negedge clk) begin
      if (rv) begin
         mon_r.val = rval;
         mon_r.err = errs;
         mon_r.lat = cyc - hs_cyc;
         act_q.push_back(mon_r);
      end
      if (gate_valid && rdy) hs_cyc = cyc;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic res_t mk(input logic v, input logic e, input int l);
      res_t r;
      r.val = v;
      r.err = e;
      r.lat = l;
      return r;
   endfunction

   function automatic string fmt(input res_t r);
      return $sformatf("val=%0b err=%0b lat=%0d", r.val, r.err, r.lat);
   endfunction

   // Checker AIG: 37 nodes, vars 17..53, output literal 106.
   task automatic build_aig();
      for (int k = 0; k < 36; k++) begin
         int v, a, b;
         v = 17 + k;
         a = 1 + (k * 7 + 3) % (v - 1);
         b = 1 + (k * 11 + 5) % (v - 1);
         lit0_t[k] = 8'(2 * a + (k & 1));
         lit1_t[k] = 8'(2 * b + ((k >> 1) & 1));
      end
      lit0_t[36] = 8'd2;
      lit1_t[36] = 8'd105;
   endtask

   function automatic logic model_eval(input logic [15:0] pv, input int n,
                                       input logic [7:0] ol);
      logic v [128];
      v[0] = 1'b0;
      for (int i = 0; i < 16; i++) v[i + 1] = pv[i];
      for (int k = 0; k < n; k++) begin
         v[17 + k] = (v[int'(lit0_t[k][7:1])] ^ lit0_t[k][0]) &
                     (v[int'(lit1_t[k][7:1])] ^ lit1_t[k][0]);
      end
      return v[int'(ol[7:1])] ^ ol[0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] pv);
      pi_vec = pv;
      if (sel) start_b = 1'b1;
      else     start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] l0, input logic [7:0] l1,
                            input logic last, input logic [7:0] ol,
                            input int bound, output logic ok, output int hc);
      gate_lit0  = l0;
      gate_lit1  = l1;
      gate_last  = last;
      out_lit    = ol;
      gate_valid = 1'b1;
      ok = 1'b0;
      hc = -1;
      for (int n = 0; n < bound && !ok; n++) begin
         @(negedge clk);
         if (rdy) begin
            ok = 1'b1;
            hc = cyc;
         end
         @(posedge clk);
         #1;
      end
      gate_valid = 1'b0;
   endtask

   task automatic wait_result(output res_t a, output res_t e);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         if (act_q.size() > 0) got = 1'b1;
         else tick();
      end
      if (got) a = act_q.pop_front();
      else     a = mk(1'b0, 1'b0, -1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = mk(1'b0, 1'b0, -2);
   endtask

   // Streams the first n checker nodes on the large instance.
   task automatic run_stream(input logic [15:0] pv, input int n,
                             input logic [7:0] ol, input bit stall,
                             output int first_c, output int last_c);
      logic ok;
      int   hc, bad;
      bad = 0;
      first_c = -1;
      last_c = -1;
      sel = 1'b0;
      do_start(pv);
      exp_q.push_back(mk(model_eval(pv, n, ol), 1'b0, 2));
      for (int k = 0; k < n; k++) begin
         if (stall) begin
            for (int s = 0; s < 6 && $urandom_range(0, 1) == 0; s++) tick();
         end
         send_beat(lit0_t[k], lit1_t[k], k == n - 1, ol, 10, ok, hc);
         if (!ok) bad++;
         if (k == 0) first_c = hc;
         last_c = hc;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stream_accept: %0d beats refused, want 0", bad);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({rdy_a, busy_a, rv_a, rval_a, err_a} !== 5'b0) begin
         errors++;
         $display("FAIL reset_large: rdy,busy,rv,val,err=%b want 00000",
                  {rdy_a, busy_a, rv_a, rval_a, err_a});
      end
      checks++;
      if ({rdy_b, busy_b, rv_b, rval_b, err_b} !== 5'b0) begin
         errors++;
         $display("FAIL reset_small: rdy,busy,rv,val,err=%b want 00000",
                  {rdy_b, busy_b, rv_b, rval_b, err_b});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      res_t a, e;
      logic ok;
      int   hc;
      sel = 1'b1;
      do_start(16'h3);
      checks++;
      if ({busy, rdy} !== 2'b11) begin
         errors++;
         $display("FAIL start_accept: busy,ready=%b want 11", {busy, rdy});
      end
      exp_q.push_back(mk(1'b1, 1'b0, 2));
      send_beat(8'd2, 8'd4, 1'b1, 8'd6, 10, ok, hc);
      wait_result(a, e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL basic_pi11: got %s want %s", fmt(a), fmt(e));
      end
      do_start(16'h1);
      exp_q.push_back(mk(1'b0, 1'b0, 2));
      send_beat(8'd2, 8'd4, 1'b1, 8'd6, 10, ok, hc);
      wait_result(a, e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL basic_pi01: got %s want %s", fmt(a), fmt(e));
      end
      do_start(16'h1);
      exp_q.push_back(mk(1'b1, 1'b0, 2));
      send_beat(8'd2, 8'd4, 1'b1, 8'd7, 10, ok, hc);
      wait_result(a, e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL basic_inv_out: got %s want %s", fmt(a), fmt(e));
      end
   endtask

   task automatic test_start_ignored();
      res_t a, e;
      logic ok;
      int   hc;
      sel = 1'b1;
      do_start(16'h3);
      exp_q.push_back(mk(1'b1, 1'b0, 2));
      send_beat(8'd2, 8'd4, 1'b0, 8'd0, 10, ok, hc);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      send_beat(8'd6, 8'd2, 1'b1, 8'd8, 10, ok, hc);
      wait_result(a, e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL start_in_stream: got %s want %s", fmt(a), fmt(e));
      end
   endtask

   task automatic test_forward_ref();
      res_t a, e;
      logic ok;
      int   hc;
      sel = 1'b1;
      do_start(16'h3);
      exp_q.push_back(mk(1'b0, 1'b1, 1));
      send_beat(8'd8, 8'd2, 1'b0, 8'd0, 10, ok, hc);
      wait_result(a, e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL fwd_ref: got %s want %s", fmt(a), fmt(e));
      end
      send_beat(8'd2, 8'd4, 1'b0, 8'd0, 3, ok, hc);
      checks++;
      if (ok !== 1'b0) begin
         errors++;
         $display("FAIL fwd_no_more_beats: accepted=%b want 0", ok);
      end
      checks++;
      if (errs !== 1'b1) begin
         errors++;
         $display("FAIL fwd_err_sticky: err=%b want 1", errs);
      end
      do_start(16'h3);
      checks++;
      if (errs !== 1'b0) begin
         errors++;
         $display("FAIL fwd_err_clear: err=%b want 0", errs);
      end
      exp_q.push_back(mk(1'b1, 1'b0, 2));
      send_beat(8'd2, 8'd4, 1'b1, 8'd6, 10, ok, hc);
      wait_result(a, e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL fwd_recover: got %s want %s", fmt(a), fmt(e));
      end
      // Output literal naming a var never written is caught in EVAL.
      do_start(16'h3);
      exp_q.push_back(mk(1'b0, 1'b1, 2));
      send_beat(8'd2, 8'd4, 1'b1, 8'd8, 10, ok, hc);
      wait_result(a, e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL out_fwd_ref: got %s want %s", fmt(a), fmt(e));
      end
   endtask

   task automatic test_overflow();
      res_t a, e;
      logic ok;
      int   hc;
      sel = 1'b1;
      do_start(16'h3);
      for (int k = 0; k < 5; k++) send_beat(8'd2, 8'd4, 1'b0, 8'd0, 10, ok, hc);
      checks++;
      if (act_q.size() !== 0 || rdy !== 1'b1) begin
         errors++;
         $display("FAIL ovf_before: results=%0d ready=%b want 0 and 1",
                  act_q.size(), rdy);
      end
      exp_q.push_back(mk(1'b0, 1'b1, 1));
      send_beat(8'd2, 8'd4, 1'b0, 8'd0, 10, ok, hc);
      wait_result(a, e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL overflow: got %s want %s", fmt(a), fmt(e));
      end
      // Zero-node AIG: one dummy beat, output = PI var 1.
      do_start(16'h1);
      checks++;
      if (errs !== 1'b0) begin
         errors++;
         $display("FAIL ovf_err_clear: err=%b want 0", errs);
      end
      exp_q.push_back(mk(1'b1, 1'b0, 2));
      send_beat(8'd1, 8'd1, 1'b1, 8'd2, 10, ok, hc);
      wait_result(a, e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL dummy_beat: got %s want %s", fmt(a), fmt(e));
      end
   endtask

   task automatic test_checker();
      res_t a, e;
      int   f, l;
      run_stream(16'h0000, 37, 8'd106, 1'b0, f, l);
      wait_result(a, e);
      checks++;
      if (a !== mk(1'b0, 1'b0, 2)) begin
         errors++;
         $display("FAIL checker_pi0: got %s want val=0 err=0 lat=2", fmt(a));
      end
      for (int i = 0; i < 200; i++) begin
         logic [15:0] pv;
         pv = 16'($urandom);
         run_stream(pv, 37, 8'd106, 1'b0, f, l);
         wait_result(a, e);
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL checker_rand pi=%h: got %s want %s", pv, fmt(a), fmt(e));
         end
      end
   endtask

   task automatic test_back_to_back();
      res_t a1, a2, e;
      int   f, l;
      run_stream(16'hA5C3, 10, 8'd52, 1'b0, f, l);
      wait_result(a1, e);
      checks++;
      if (a1 !== e) begin
         errors++;
         $display("FAIL b2b_result: got %s want %s", fmt(a1), fmt(e));
      end
      checks++;
      if (l - f !== 9) begin
         errors++;
         $display("FAIL b2b_throughput: span=%0d cycles want 9", l - f);
      end
      run_stream(16'hA5C3, 10, 8'd52, 1'b1, f, l);
      wait_result(a2, e);
      checks++;
      if (a2 !== e) begin
         errors++;
         $display("FAIL stall_result: got %s want %s", fmt(a2), fmt(e));
      end
      checks++;
      if (a2.val !== a1.val) begin
         errors++;
         $display("FAIL stall_vs_b2b: stalled=%b unstalled=%b", a2.val, a1.val);
      end
   endtask

   task automatic test_reset_mid_stream();
      res_t a, e;
      logic ok;
      int   hc, f, l;
      logic [15:0] pv;
      sel = 1'b0;
      do_start(16'hFFFF);
      for (int k = 0; k < 3; k++) send_beat(lit0_t[k], lit1_t[k], 1'b0, 8'd0, 10, ok, hc);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({rdy, busy, errs, rval} !== 4'b0) begin
         errors++;
         $display("FAIL rst_mid_outputs: ready,busy,err,val=%b want 0000",
                  {rdy, busy, errs, rval});
      end
      repeat (5) tick();
      checks++;
      if (act_q.size() !== 0) begin
         errors++;
         $display("FAIL rst_mid_no_result: results=%0d want 0", act_q.size());
      end
      pv = 16'h3C5A;
      run_stream(pv, 37, 8'd106, 1'b0, f, l);
      wait_result(a, e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL rst_mid_rerun: got %s want %s", fmt(a), fmt(e));
      end
   endtask

   initial begin
      rst        = 1'b1;
      start_a    = 1'b0;
      start_b    = 1'b0;
      pi_vec     = '0;
      gate_valid = 1'b0;
      gate_last  = 1'b0;
      gate_lit0  = '0;
      gate_lit1  = '0;
      out_lit    = '0;
      sel        = 1'b0;
      build_aig();
      test_reset();
      test_basic();
      test_start_ignored();
      test_forward_ref();
      test_overflow();
      test_checker();
      test_back_to_back();
      test_reset_mid_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
